mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 1, extra memory cycles per access (legal 0..7).
REQ-002 Parameter MAX_D_STREAK, default 2, consecutive data grants allowed while fetch waits (legal 1..3).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 IF_REQ  in  1  fetch request, held until IF_ACK seen.
REQ-006 IF_ADDR  in  32  fetch address.
REQ-007 IF_RDATA  out  32  fetched instruction, registered.
REQ-008 IF_ACK  out  1  fetch complete, one-cycle pulse.
REQ-009 D_REQ  in  1  data request, held until D_ACK seen.
REQ-010 D_WE  in  1  1 = write, 0 = read.
REQ-011 D_ADDR  in  32  data address.
REQ-012 D_WDATA  in  32  data write value.
REQ-013 D_RDATA  out  32  data read value, registered.
REQ-014 D_ACK  out  1  data access complete, one-cycle pulse.
REQ-015 MEM_EN  out  1  shared memory enable.
REQ-016 MEM_WE  out  1  shared memory write strobe.
REQ-017 MEM_ADDR  out  32  shared memory address.
REQ-018 MEM_WDATA  out  32  shared memory write data.
REQ-019 MEM_RDATA  in  32  shared memory read data, valid while MEM_EN high.
REQ-020 STALL_IF  out  1  freeze PC/IF-ID: IF_REQ & ~IF_ACK.
REQ-021 STALL_MEM  out  1  freeze pipeline at MEM stage: D_REQ & ~D_ACK.

Function
REQ-022 FSM states IDLE, BUSY, RESP; one memory access in flight at most.
REQ-023 IDLE: requests sampled each edge; no request -> stay IDLE, MEM_EN=0.
REQ-024 IDLE, one request -> grant it, latch address/WE/WDATA into MEM_* registers, load wait counter with WAIT_STATES, go BUSY.
REQ-025 IDLE, both requests -> grant data, unless streak counter == MAX_D_STREAK, then grant fetch.
REQ-026 Streak counter: +1 on data grant while IF_REQ high; cleared on fetch grant or on data grant with IF_REQ low; saturates at MAX_D_STREAK.
REQ-027 Fetch grant drives MEM_WE=0 regardless of D_WE; data grant drives MEM_WE=D_WE.
REQ-028 BUSY: MEM_EN=1, MEM_ADDR/MEM_WE/MEM_WDATA held constant; counter != 0 -> decrement, stay BUSY.
REQ-029 BUSY with counter == 0: at edge, capture MEM_RDATA into granted port's RDATA (reads only; write leaves D_RDATA unchanged), go RESP.
REQ-030 RESP: granted port's ACK=1, MEM_EN=0, MEM_WE=0; next edge -> IDLE unconditionally; requests ignored in RESP.
REQ-031 Latency: request sampled at edge k -> ACK high exactly in cycle after edge k+WAIT_STATES+1; next grant no earlier than edge k+WAIT_STATES+3.
REQ-032 Requester still asserting REQ in IDLE after its ACK = new transaction (back-to-back fetch legal).
REQ-033 IF_RDATA/D_RDATA hold value until the next read ACK on that port.
REQ-034 Input changes during BUSY/RESP have no effect on the in-flight access.
REQ-035 IF_ACK and D_ACK never high in the same cycle.

Reset
REQ-036 rst_n low at edge -> state IDLE, counter 0, streak 0, all outputs 0 (RDATA, ACKs, MEM_*), STALLs follow REQ-020/021.
REQ-037 Reset during BUSY or RESP aborts the access: no ACK issued, MEM_EN low from the cycle after the reset edge.
REQ-038 Requests held through reset release are sampled at the first edge with rst_n high.

Verification
REQ-039 WAIT_STATES=1, IF_REQ at IF_ADDR=0x40, MEM_RDATA=0x8C220004 -> MEM_EN high 2 cycles, IF_ACK in cycle after edge k+2, IF_RDATA=0x8C220004, STALL_IF low same cycle.
REQ-040 Both requests in IDLE, D_WE=1, D_ADDR=0x100, D_WDATA=0xDEADBEEF -> data granted first, MEM_WE=1 with that addr/data, D_ACK then fetch granted; D_RDATA unchanged.
REQ-041 MAX_D_STREAK=2, D_REQ and IF_REQ continuously high -> grant order D, D, IF, D, D, IF; no back-to-back ACKs on either port.
REQ-042 WAIT_STATES=0, data read of 0x200 returning 0x12345678 -> D_ACK in cycle after edge k+1, D_RDATA=0x12345678.
REQ-043 rst_n low one cycle mid-BUSY -> no ACK, MEM_EN 0 next cycle, all outputs 0, pending IF_REQ re-granted after release.
REQ-044 Fetch request with D_WE=1, D_REQ=0 -> MEM_WE stays 0 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of one shared single-port memory
//
// One access is in flight at a time. Data wins ties unless it has already taken
// MAX_D_STREAK grants in a row while fetch was waiting; then fetch goes first.
// Each access holds MEM_EN for WAIT_STATES+1 cycles, then the granted port sees a
// one-cycle ACK with registered read data.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   IF_REQ, IF_ADDR                 fetch request (held until IF_ACK), fetch address
//   IF_RDATA, IF_ACK                registered instruction, completion pulse
//   D_REQ, D_WE, D_ADDR, D_WDATA    data request (held until D_ACK), write flag, addr, wdata
//   D_RDATA, D_ACK                  registered read data, completion pulse
//   MEM_EN, MEM_WE, MEM_ADDR,
//   MEM_WDATA, MEM_RDATA            shared memory interface
//   STALL_IF, STALL_MEM             pipeline freezes while a request is outstanding
module mem_arbiter #(
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned MAX_D_STREAK = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic [31:0] IF_RDATA,
  output logic        IF_ACK,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic [31:0] D_RDATA,
  output logic        D_ACK,
  output logic        MEM_EN,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  output logic        STALL_IF,
  output logic        STALL_MEM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_INIT  = 3'(WAIT_STATES);
  localparam logic [1:0] STREAK_MAX = 2'(MAX_D_STREAK);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  wait_cnt;
  logic [1:0]  streak;
  logic        grant_d;   // 1: in-flight access belongs to the data port
  logic        we_q;      // write flag of the in-flight access
  logic        grant_any;
  logic        pick_d;

  assign grant_any = (state == IDLE) && (IF_REQ || D_REQ);
  // Fetch only overrides a pending data request once data has used up its streak.
  assign pick_d    = D_REQ && !(IF_REQ && (streak == STREAK_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    MEM_EN    = 1'b0;
    MEM_WE    = 1'b0;
    IF_ACK    = 1'b0;
    D_ACK     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        MEM_EN = 1'b1;
        MEM_WE = we_q;
        if (wait_cnt == 3'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        IF_ACK    = !grant_d;
        D_ACK     = grant_d;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt  <= 3'd0;
      streak    <= 2'd0;
      grant_d   <= 1'b0;
      we_q      <= 1'b0;
      MEM_ADDR  <= 32'd0;
      MEM_WDATA <= 32'd0;
      IF_RDATA  <= 32'd0;
      D_RDATA   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            grant_d   <= pick_d;
            wait_cnt  <= WAIT_INIT;
            MEM_WDATA <= D_WDATA;
            if (pick_d) begin
              we_q     <= D_WE;
              MEM_ADDR <= D_ADDR;
              // The streak only grows while fetch is actually being held off.
              if (IF_REQ) begin
                streak <= (streak == STREAK_MAX) ? streak : streak + 2'd1;
              end else begin
                streak <= 2'd0;
              end
            end else begin
              we_q     <= 1'b0;
              MEM_ADDR <= IF_ADDR;
              streak   <= 2'd0;
            end
          end
        end
        BUSY: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else if (!grant_d) begin
            IF_RDATA <= MEM_RDATA;
          end else if (!we_q) begin
            D_RDATA <= MEM_RDATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign STALL_IF  = IF_REQ && !IF_ACK;
  assign STALL_MEM = D_REQ && !D_ACK;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int W    = 1;
  localparam int MAXS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, stall_if, stall_mem;

  logic        force_en;
  logic [31:0] force_val;

  logic        z_if_req, z_d_req, z_d_we;
  logic [31:0] z_if_addr, z_d_addr, z_d_wdata, z_mem_rdata;
  logic [31:0] z_if_rdata, z_d_rdata, z_mem_addr, z_mem_wdata;
  logic        z_if_ack, z_d_ack, z_mem_en, z_mem_we, z_stall_if, z_stall_mem;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  assign mem_rdata = force_en ? force_val : mem_model(mem_addr);

  mem_arbiter #(.WAIT_STATES(W), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_RDATA(if_rdata), .IF_ACK(if_ack),
    .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_RDATA(d_rdata), .D_ACK(d_ack),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata), .STALL_IF(stall_if), .STALL_MEM(stall_mem)
  );

  mem_arbiter #(.WAIT_STATES(0), .MAX_D_STREAK(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .IF_REQ(z_if_req), .IF_ADDR(z_if_addr), .IF_RDATA(z_if_rdata), .IF_ACK(z_if_ack),
    .D_REQ(z_d_req), .D_WE(z_d_we), .D_ADDR(z_d_addr), .D_WDATA(z_d_wdata),
    .D_RDATA(z_d_rdata), .D_ACK(z_d_ack),
    .MEM_EN(z_mem_en), .MEM_WE(z_mem_we), .MEM_ADDR(z_mem_addr), .MEM_WDATA(z_mem_wdata),
    .MEM_RDATA(z_mem_rdata), .STALL_IF(z_stall_if), .STALL_MEM(z_stall_mem)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  vec_t tbl [6];

  int          ack_t [$];
  int          ack_p [$];

  // Random-phase reference: arbitration decided per edge from the request rules,
  // timing derived from the grant edge with plain arithmetic.
  int          free_at, g_edge, streak_m;
  bit          gvalid, g_d, g_we;
  logic [31:0] g_addr, g_wdata, exp_if_rd, exp_d_rd;

  initial begin
    int lat, en_n, we_n, bad_addr, other_ack, stall_bad, d_tick, if_tick;
    bit exp_en, exp_ifack, exp_dack;

    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    force_en = 1'b1; force_val = 32'h1357_9BDF;
    z_if_req = 1'b0; z_d_req = 1'b0; z_d_we = 1'b0;
    z_if_addr = 32'd0; z_d_addr = 32'd0; z_d_wdata = 32'd0; z_mem_rdata = 32'd0;

    tbl[0] = '{"fetch40",   1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'h8C22_0004, 32'h8C22_0004, 32'h0};
    tbl[1] = '{"dread200",  1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'h1111_2222, 32'h8C22_0004, 32'h1111_2222};
    tbl[2] = '{"dwrite100", 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h5555_5555, 32'h8C22_0004, 32'h1111_2222};
    tbl[3] = '{"fetch_dwe", 1'b0, 1'b1, 32'h0000_0044, 32'h0,         32'h0000_0013, 32'h0000_0013, 32'h1111_2222};
    tbl[4] = '{"dreadtop",  1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFF, 32'h0000_0013, 32'hFFFF_FFFF};
    tbl[5] = '{"fetch0",    1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};

    // Reset state, with a fetch request held across reset release.
    if_req = 1'b1; if_addr = 32'h40;
    tick(); tick();
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_if_ack", {31'd0, if_ack}, 32'd0);
    check("rst_d_ack", {31'd0, d_ack}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_stall_if", {31'd0, stall_if}, 32'd1);
    check("rst_stall_mem", {31'd0, stall_mem}, 32'd0);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      tick();
      if (if_ack) lat = i;
    end
    check("release_lat", lat, W + 2);
    check("release_rdata", if_rdata, 32'h1357_9BDF);
    if_req = 1'b0;
    tick();

    // Single transactions from IDLE; unrelated inputs are scrambled while busy.
    for (int v = 0; v < 6; v++) begin
      force_val = tbl[v].rdata;
      d_we = tbl[v].we;
      if (tbl[v].is_d) begin
        d_req = 1'b1; d_addr = tbl[v].addr; d_wdata = tbl[v].wdata;
      end else begin
        if_req = 1'b1; if_addr = tbl[v].addr;
      end
      lat = 0; en_n = 0; we_n = 0; bad_addr = 0; other_ack = 0; stall_bad = 0;
      for (int i = 1; i <= 12 && lat == 0; i++) begin
        tick();
        if (mem_en) begin
          en_n++;
          if (mem_we) we_n++;
          if (mem_addr !== tbl[v].addr) bad_addr++;
          if (tbl[v].is_d && tbl[v].we && mem_wdata !== tbl[v].wdata) bad_addr++;
        end
        if (tbl[v].is_d ? if_ack : d_ack) other_ack++;
        if (tbl[v].is_d ? d_ack : if_ack) begin
          lat = i;
          if ((tbl[v].is_d ? stall_mem : stall_if) !== 1'b0) stall_bad++;
        end else if ((tbl[v].is_d ? stall_mem : stall_if) !== 1'b1) begin
          stall_bad++;
        end
        if (tbl[v].is_d) begin
          if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
        end else begin
          if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        end
      end
      if_req = 1'b0; d_req = 1'b0;
      tick();
      check({tbl[v].name, "_lat"}, lat, W + 2);
      check({tbl[v].name, "_en_cycles"}, en_n, W + 1);
      check({tbl[v].name, "_we_cycles"}, we_n, (tbl[v].is_d && tbl[v].we) ? W + 1 : 0);
      check({tbl[v].name, "_held_addr"}, bad_addr, 0);
      check({tbl[v].name, "_other_ack"}, other_ack, 0);
      check({tbl[v].name, "_stall"}, stall_bad, 0);
      check({tbl[v].name, "_if_rdata"}, if_rdata, tbl[v].exp_if);
      check({tbl[v].name, "_d_rdata"}, d_rdata, tbl[v].exp_d);
    end

    // Both requesters at once: data write goes first, then the fetch.
    force_val = 32'h0BAD_F00D;
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("both_mem_en", {31'd0, mem_en}, 32'd1);
    check("both_mem_we", {31'd0, mem_we}, 32'd1);
    check("both_mem_addr", mem_addr, 32'h100);
    check("both_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    d_tick = 0; if_tick = 0;
    for (int i = 2; i <= 12 && if_tick == 0; i++) begin
      tick();
      if (d_ack && d_tick == 0) begin d_tick = i; d_req = 1'b0; end
      if (if_ack) begin if_tick = i; if_req = 1'b0; end
    end
    tick();
    check("both_d_ack_tick", d_tick, W + 2);
    check("both_if_ack_tick", if_tick, 2 * W + 5);
    check("both_d_rdata_kept", d_rdata, 32'hFFFF_FFFF);
    check("both_if_rdata", if_rdata, 32'h0BAD_F00D);

    // Streak limit with both requests held continuously.
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    ack_t.delete(); ack_p.delete();
    for (int i = 1; i <= 6 * (W + 3); i++) begin
      tick();
      if (if_ack) begin ack_t.push_back(i); ack_p.push_back(0); end
      if (d_ack) begin ack_t.push_back(i); ack_p.push_back(1); end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    check("streak_ack_count", ack_t.size(), 6);
    for (int g = 0; g < 6 && g < ack_t.size(); g++) begin
      check($sformatf("streak_port_%0d", g), ack_p[g], (g % 3 == 2) ? 0 : 1);
      check($sformatf("streak_tick_%0d", g), ack_t[g], (W + 2) + g * (W + 3));
    end

    // Reset pulse in the middle of a fetch aborts it; the held request restarts.
    force_val = 32'h600D_CAFE;
    if_req = 1'b1; if_addr = 32'h60;
    tick();
    check("abort_busy_en", {31'd0, mem_en}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("abort_mem_en", {31'd0, mem_en}, 32'd0);
    check("abort_if_ack", {31'd0, if_ack}, 32'd0);
    check("abort_if_rdata", if_rdata, 32'd0);
    check("abort_d_rdata", d_rdata, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_stall_if", {31'd0, stall_if}, 32'd1);
    rst_n = 1'b1;
    lat = 0; other_ack = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      tick();
      if (d_ack) other_ack++;
      if (if_ack) lat = i;
    end
    if_req = 1'b0;
    tick();
    check("abort_regrant_lat", lat, W + 2);
    check("abort_regrant_d_ack", other_ack, 0);
    check("abort_regrant_rdata", if_rdata, 32'h600D_CAFE);

    // Zero wait states: data read completes one edge after the grant.
    z_mem_rdata = 32'h1234_5678;
    z_d_req = 1'b1; z_d_we = 1'b0; z_d_addr = 32'h200; z_d_wdata = 32'd0;
    tick();
    check("ws0_busy_en", {31'd0, z_mem_en}, 32'd1);
    check("ws0_busy_addr", z_mem_addr, 32'h200);
    check("ws0_busy_wdata", z_mem_wdata, 32'd0);
    check("ws0_busy_ack", {31'd0, z_d_ack}, 32'd0);
    check("ws0_busy_stall", {31'd0, z_stall_mem}, 32'd1);
    tick();
    check("ws0_d_ack", {31'd0, z_d_ack}, 32'd1);
    check("ws0_resp_en", {31'd0, z_mem_en}, 32'd0);
    check("ws0_resp_we", {31'd0, z_mem_we}, 32'd0);
    check("ws0_if_ack", {31'd0, z_if_ack}, 32'd0);
    check("ws0_stall_mem", {31'd0, z_stall_mem}, 32'd0);
    check("ws0_stall_if", {31'd0, z_stall_if}, 32'd0);
    check("ws0_d_rdata", z_d_rdata, 32'h1234_5678);
    check("ws0_if_rdata", z_if_rdata, 32'd0);
    z_d_req = 1'b0;
    tick();

    // Randomized traffic against the edge-arithmetic reference.
    force_en = 1'b0;
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    free_at = 0; gvalid = 1'b0; g_d = 1'b0; g_we = 1'b0; g_edge = 0; streak_m = 0;
    g_addr = 32'd0; g_wdata = 32'd0; exp_if_rd = 32'd0; exp_d_rd = 32'd0;
    for (int e = 0; e < 1500; e++) begin
      @(posedge clk);
      if (e >= free_at && (if_req || d_req)) begin
        g_d = d_req && !(if_req && streak_m == MAXS);
        if (g_d) streak_m = if_req ? ((streak_m + 1 > MAXS) ? MAXS : streak_m + 1) : 0;
        else     streak_m = 0;
        gvalid  = 1'b1;
        g_edge  = e;
        free_at = e + W + 3;
        g_we    = g_d ? d_we : 1'b0;
        g_addr  = g_d ? d_addr : if_addr;
        g_wdata = d_wdata;
      end
      @(negedge clk);
      exp_en    = gvalid && e >= g_edge && e <= g_edge + W;
      exp_ifack = gvalid && e == g_edge + W + 1 && !g_d;
      exp_dack  = gvalid && e == g_edge + W + 1 && g_d;
      if (exp_ifack) exp_if_rd = mem_model(g_addr);
      if (exp_dack && !g_we) exp_d_rd = mem_model(g_addr);
      check("rnd_mem_en", {31'd0, mem_en}, {31'd0, exp_en});
      check("rnd_mem_we", {31'd0, mem_we}, {31'd0, exp_en && g_we});
      check("rnd_if_ack", {31'd0, if_ack}, {31'd0, exp_ifack});
      check("rnd_d_ack", {31'd0, d_ack}, {31'd0, exp_dack});
      check("rnd_if_rdata", if_rdata, exp_if_rd);
      check("rnd_d_rdata", d_rdata, exp_d_rd);
      check("rnd_stall_if", {31'd0, stall_if}, {31'd0, if_req && !exp_ifack});
      check("rnd_stall_mem", {31'd0, stall_mem}, {31'd0, d_req && !exp_dack});
      if (exp_en) begin
        check("rnd_mem_addr", mem_addr, g_addr);
        if (g_we) check("rnd_mem_wdata", mem_wdata, g_wdata);
      end
      if (if_req) begin
        if (exp_ifack) begin
          if_req = 1'($urandom_range(0, 1));
          if_addr = $urandom;
        end
      end else begin
        if_addr = $urandom;
        if ($urandom_range(0, 2) == 0) if_req = 1'b1;
      end
      if (d_req) begin
        if (exp_dack) begin
          d_req = 1'($urandom_range(0, 1));
          d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
        end
      end else begin
        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
        if ($urandom_range(0, 2) == 0) d_req = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
